nibble_serial_adder: RTL and testbench

Multi-cycle WIDTH-bit add/subtract unit that processes one 4-bit nibble per clock through a single 4-bit carry-lookahead adder slice. It feeds that slice LSB nibble first and chains the carry through a register. It assembles the full Sum, CarryOut and signed Overflow, and signals completion with a one-cycle Done pulse.
It sits upstream of the 4-bit lookahead adder and trades latency for area when wide operands must share one slice.

---
 rtl/nibble_serial_adder_pkg.sv | 17 +
 rtl/nibble_serial_adder_full_adder4.sv | 28 ++
 rtl/nibble_serial_adder.sv | 95 +++++++++
 tb/tb_nibble_serial_adder.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/nibble_serial_adder_pkg.sv
// rtl/nibble_serial_adder_pkg.sv - shared state encoding and sizing helpers for the nibble-serial adder
package nibble_serial_adder_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Nibble counter width; never narrower than one bit.
    function automatic int cnt_width(input int nibbles);
        return (nibbles > 1) ? $clog2(nibbles) : 1;
    endfunction

endpackage

// File: rtl/nibble_serial_adder_full_adder4.sv
// rtl/nibble_serial_adder_full_adder4.sv - 4-bit carry-lookahead adder slice
module FullAdder4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       carry_in,
    output logic [3:0] sum,
    output logic       carry_out
);

    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    assign g = a & b;
    assign p = a ^ b;

    // All carries derived directly from generate/propagate terms.
    assign c[0] = carry_in;
    assign c[1] = g[0] | (p[0] & c[0]);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & c[0]);

    assign sum       = p ^ c[3:0];
    assign carry_out = c[4];

endmodule

// File: rtl/nibble_serial_adder.sv
// rtl/nibble_serial_adder.sv - WIDTH-bit add/subtract using one 4-bit slice, one nibble per clock
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Sub,
    input  logic             CarryIn,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Ready,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Sum,
    output logic             CarryOut,
    output logic             Overflow
);

    localparam int NIBBLES = WIDTH / NIBBLE_W;
    localparam int CW      = cnt_width(NIBBLES);
    localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

    state_t           state;
    state_t           next_state;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [3:0]       slice_sum;
    logic             slice_cout;
    logic             accept;

    assign Ready  = (state == ST_IDLE) || (state == ST_DONE);
    assign Busy   = (state == ST_RUN);
    assign Done   = (state == ST_DONE);
    assign accept = Start && Ready;

    FullAdder4 u_slice (
        .a         (op_a[cnt*NIBBLE_W +: NIBBLE_W]),
        .b         (op_b[cnt*NIBBLE_W +: NIBBLE_W]),
        .carry_in  (carry),
        .sum       (slice_sum),
        .carry_out (slice_cout)
    );

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (Start) next_state = ST_RUN;
            ST_RUN:  if (cnt == LAST) next_state = ST_DONE;
            ST_DONE: next_state = Start ? ST_RUN : ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            op_a     <= '0;
            op_b     <= '0;
            carry    <= 1'b0;
            cnt      <= '0;
            Sum      <= '0;
            CarryOut <= 1'b0;
            Overflow <= 1'b0;
        end else if (accept) begin
            // Subtraction is A + ~B + 1, so CarryOut=1 means no borrow.
            op_a     <= A;
            op_b     <= Sub ? ~B : B;
            carry    <= Sub ? 1'b1 : CarryIn;
            cnt      <= '0;
            CarryOut <= 1'b0;
            Overflow <= 1'b0;
        end else if (state == ST_RUN) begin
            Sum[cnt*NIBBLE_W +: NIBBLE_W] <= slice_sum;
            carry <= slice_cout;
            cnt   <= cnt + 1'b1;
            if (cnt == LAST) begin
                CarryOut <= slice_cout;
                Overflow <= (op_a[WIDTH-1] == op_b[WIDTH-1]) && (slice_sum[3] != op_a[WIDTH-1]);
            end
        end
    end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb/tb_nibble_serial_adder.sv - directed self-checking bench for nibble_serial_adder
module tb_nibble_serial_adder;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        Start = 1'b0;
    logic        Sub = 1'b0;
    logic        CarryIn = 1'b0;
    logic [15:0] A = '0;
    logic [15:0] B = '0;
    logic        Ready;
    logic        Busy;
    logic        Done;
    logic [15:0] Sum;
    logic        CarryOut;
    logic        Overflow;

    int checks = 0;
    int errors = 0;

    nibble_serial_adder #(.WIDTH(16)) dut (
        .Clock(Clock), .Reset(Reset), .Start(Start), .Sub(Sub), .CarryIn(CarryIn),
        .A(A), .B(B), .Ready(Ready), .Busy(Busy), .Done(Done),
        .Sum(Sum), .CarryOut(CarryOut), .Overflow(Overflow)
    );

    always #5 Clock = ~Clock;

    // Drives one request and counts edges (sampling edge = 1) until Done, bounded at 20.
    task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic sub, input logic cin,
                         output int edges, output int busy_cycles);
        @(negedge Clock);
        A = a; B = b; Sub = sub; CarryIn = cin; Start = 1'b1;
        edges = 0; busy_cycles = 0;
        while (edges < 20) begin
            @(posedge Clock); #1;
            Start = 1'b0;
            edges++;
            if (Busy) busy_cycles++;
            if (Done) break;
        end
    endtask

    task automatic test_reset();
        #1;
        checks++; if (Sum !== 16'h0000) begin errors++; $display("FAIL reset_sum: got %h expected 0000", Sum); end
        checks++; if ({Ready, Busy, Done, CarryOut, Overflow} !== 5'b10000) begin
            errors++; $display("FAIL reset_flags: got %b expected 10000", {Ready, Busy, Done, CarryOut, Overflow}); end
        @(negedge Clock); Reset = 1'b0;
    endtask

    task automatic test_add_basic();
        int e, bc;
        do_op(16'h1234, 16'h4321, 1'b0, 1'b0, e, bc);
        checks++; if (e !== 5) begin errors++; $display("FAIL basic_latency: got %0d expected 5", e); end
        checks++; if (bc !== 4) begin errors++; $display("FAIL basic_busy: got %0d expected 4", bc); end
        checks++; if ({Sum, CarryOut, Overflow} !== {16'h5555, 2'b00}) begin
            errors++; $display("FAIL basic_result: got %h/%b/%b expected 5555/0/0", Sum, CarryOut, Overflow); end
        @(posedge Clock); #1;
        checks++; if ({Done, Ready, Sum} !== {2'b01, 16'h5555}) begin
            errors++; $display("FAIL basic_done_pulse: got done=%b ready=%b sum=%h expected 0/1/5555", Done, Ready, Sum); end
    endtask

    task automatic test_carry_ripple();
        int e, bc;
        do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, e, bc);
        checks++; if ({Sum, CarryOut, Overflow} !== {16'h0000, 2'b10}) begin
            errors++; $display("FAIL ripple_result: got %h/%b/%b expected 0000/1/0", Sum, CarryOut, Overflow); end
        do_op(16'h0001, 16'h0002, 1'b0, 1'b1, e, bc);
        checks++; if ({Sum, CarryOut, Overflow} !== {16'h0004, 2'b00}) begin
            errors++; $display("FAIL carry_in_result: got %h/%b/%b expected 0004/0/0", Sum, CarryOut, Overflow); end
    endtask

    task automatic test_overflow();
        int e, bc;
        do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, e, bc);
        checks++; if ({Sum, CarryOut, Overflow} !== {16'h8000, 2'b01}) begin
            errors++; $display("FAIL ovf_add: got %h/%b/%b expected 8000/0/1", Sum, CarryOut, Overflow); end
        do_op(16'h8000, 16'h0001, 1'b1, 1'b0, e, bc);
        checks++; if ({Sum, CarryOut, Overflow} !== {16'h7FFF, 2'b11}) begin
            errors++; $display("FAIL ovf_sub: got %h/%b/%b expected 7fff/1/1", Sum, CarryOut, Overflow); end
    endtask

    task automatic test_sub_borrow();
        int e, bc;
        do_op(16'h0005, 16'h0007, 1'b1, 1'b1, e, bc);
        checks++; if ({Sum, CarryOut, Overflow} !== {16'hFFFE, 2'b00}) begin
            errors++; $display("FAIL sub_borrow: got %h/%b/%b expected fffe/0/0", Sum, CarryOut, Overflow); end
    endtask

    task automatic test_back_to_back();
        int e;
        @(negedge Clock);
        A = 16'h0001; B = 16'h0001; Sub = 1'b0; CarryIn = 1'b0; Start = 1'b1;
        @(posedge Clock); #1; Start = 1'b0;
        checks++; if ({Busy, Ready} !== 2'b10) begin errors++; $display("FAIL b2b_busy: got busy=%b ready=%b expected 1/0", Busy, Ready); end
        @(negedge Clock);
        A = 16'hAAAA; Start = 1'b1;
        @(posedge Clock); #1; Start = 1'b0;
        e = 2;
        while (e < 20 && !Done) begin @(posedge Clock); #1; e++; end
        checks++; if (e !== 5) begin errors++; $display("FAIL b2b_first_latency: got %0d expected 5", e); end
        checks++; if ({Sum, Ready} !== {16'h0002, 1'b1}) begin
            errors++; $display("FAIL b2b_first_result: got %h ready=%b expected 0002/1", Sum, Ready); end
        A = 16'h0003; B = 16'h0004; Start = 1'b1;
        e = 0;
        while (e < 20) begin
            @(posedge Clock); #1; Start = 1'b0; e++;
            if (Done) break;
        end
        checks++; if (e !== 5) begin errors++; $display("FAIL b2b_second_latency: got %0d expected 5", e); end
        checks++; if (Sum !== 16'h0007) begin errors++; $display("FAIL b2b_second_result: got %h expected 0007", Sum); end
    endtask

    task automatic test_async_reset();
        int e, bc, seen;
        @(negedge Clock);
        A = 16'h1111; B = 16'h2222; Sub = 1'b0; CarryIn = 1'b0; Start = 1'b1;
        repeat (3) begin @(posedge Clock); #1; Start = 1'b0; end
        #2; Reset = 1'b1; #1;
        checks++; if ({Sum, CarryOut, Overflow, Done, Busy, Ready} !== {16'h0000, 5'b00001}) begin
            errors++; $display("FAIL async_reset: got sum=%h co=%b ov=%b done=%b busy=%b ready=%b expected 0000/0/0/0/0/1",
                               Sum, CarryOut, Overflow, Done, Busy, Ready); end
        @(negedge Clock); Reset = 1'b0;
        seen = 0;
        repeat (8) begin @(posedge Clock); #1; if (Done) seen++; end
        checks++; if (seen !== 0) begin errors++; $display("FAIL reset_no_done: got %0d pulses expected 0", seen); end
        do_op(16'h00FF, 16'h0001, 1'b0, 1'b0, e, bc);
        checks++; if ({Sum, CarryOut, Overflow, e} !== {16'h0100, 2'b00, 32'd5}) begin
            errors++; $display("FAIL post_reset_op: got %h/%b/%b edges=%0d expected 0100/0/0 edges=5", Sum, CarryOut, Overflow, e); end
    endtask

    initial begin
        test_reset();
        test_add_basic();
        test_carry_ripple();
        test_overflow();
        test_sub_borrow();
        test_back_to_back();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
